// File: rtl/cpu_seq_ctrl_pkg.sv
// Shared types and helpers for the cpu_seq_ctrl phase sequencer.
// P_HALT exists only when SEQ_STEP_EN is defined.
package cpu_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    P_RST,
    P_FETCH,
    P_CALC,
    P_WRITE,
    P_NXT,
    P_FINISH,
    P_ERR
`ifdef SEQ_STEP_EN
    , P_HALT
`endif
  } SeqPhase;

  function automatic logic phase_busy(SeqPhase p);
    return !(p inside {P_RST, P_FINISH, P_ERR});
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_cycle_cnt.sv
// Loadable up-counter with enable, synchronous clear and terminal-count compare.
module seq_cycle_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (load)  cnt <= load_val;
    else if (en)    cnt <= cnt + W'(1);
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Parametrised CPU phase sequencer: FETCH -> CALC (watchdog) -> WRITE -> NXT per line.
// Optional single-step support (step_mode/step ports, P_HALT) under `define SEQ_STEP_EN.
module cpu_seq_ctrl
  import cpu_seq_ctrl_pkg::*;
#(
  parameter int unsigned FETCH_CYCLES = 4,
  parameter int unsigned WB_CYCLES    = 1,
  parameter int unsigned CALC_TIMEOUT = 255,
  parameter int unsigned ERR_W        = 4,
  parameter int unsigned LINE_W       = 8,
  localparam int unsigned SUB_W = cnt_width((FETCH_CYCLES > WB_CYCLES) ? FETCH_CYCLES : WB_CYCLES)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              clr,
  input  logic              stall,
  input  logic              nxt_line,
  input  logic              finish,
  input  logic              err,
  input  logic [ERR_W-1:0]  err_code,
`ifdef SEQ_STEP_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  output SeqPhase           phase,
  output logic [SUB_W-1:0]  sub_idx,
  output logic [LINE_W-1:0] line_cnt,
  output logic [ERR_W-1:0]  err_q,
  output logic              busy
);

  localparam int unsigned       CW         = cnt_width(CALC_TIMEOUT);
  localparam logic [SUB_W-1:0]  FETCH_LAST = SUB_W'(FETCH_CYCLES - 1);
  localparam logic [SUB_W-1:0]  WB_LAST    = SUB_W'(WB_CYCLES - 1);
  localparam logic [CW-1:0]     CALC_LAST  = CW'((CALC_TIMEOUT == 0) ? 0 : CALC_TIMEOUT - 1);
  localparam logic [ERR_W-1:0]  ERR_WDOG   = '1;

  SeqPhase           phase_q, phase_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ERR_W-1:0]  errq_r, errq_d;
  logic              sub_clr, sub_en, sub_tc;
  logic              calc_clr, calc_en, calc_tc;
  logic [SUB_W-1:0]  sub_term;
  logic [CW-1:0]     calc_cnt;
  logic              wdog_fire;

  // FETCH and WRITE share one index counter; only the terminal value differs.
  assign sub_term  = (phase_q == P_WRITE) ? WB_LAST : FETCH_LAST;
  assign wdog_fire = (CALC_TIMEOUT != 0) && calc_tc;

  seq_cycle_cnt #(.W(SUB_W)) u_sub_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (sub_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (sub_en),
    .term     (sub_term),
    .cnt      (sub_idx),
    .tc       (sub_tc)
  );

  seq_cycle_cnt #(.W(CW)) u_calc_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (calc_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (calc_en),
    .term     (CALC_LAST),
    .cnt      (calc_cnt),
    .tc       (calc_tc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q <= P_RST;
      line_q  <= '0;
      errq_r  <= '0;
    end else begin
      phase_q <= phase_d;
      line_q  <= line_d;
      errq_r  <= errq_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    line_d   = line_q;
    errq_d   = errq_r;
    sub_clr  = 1'b0;
    sub_en   = 1'b0;
    calc_clr = 1'b0;
    calc_en  = 1'b0;
    if (err) begin
      // First error code sticks for as long as the sequencer stays in P_ERR.
      phase_d = P_ERR;
      if (phase_q != P_ERR) errq_d = err_code;
    end else if (!stall) begin
      case (phase_q)
        P_RST: begin
          if (start) begin
            phase_d  = P_FETCH;
            sub_clr  = 1'b1;
            calc_clr = 1'b1;
          end
        end
        P_FETCH: begin
          if (sub_tc) begin
            phase_d = P_CALC;
            sub_clr = 1'b1;
          end else begin
            sub_en = 1'b1;
          end
        end
        P_CALC: begin
          if (finish) begin
            phase_d  = P_FINISH;
            calc_clr = 1'b1;
          end else if (nxt_line) begin
            phase_d  = P_WRITE;
            calc_clr = 1'b1;
          end else if (wdog_fire) begin
            phase_d  = P_ERR;
            errq_d   = ERR_WDOG;
            calc_clr = 1'b1;
          end else begin
            calc_en = 1'b1;
          end
        end
        P_WRITE: begin
          if (sub_tc) begin
            phase_d = P_NXT;
            sub_clr = 1'b1;
          end else begin
            sub_en = 1'b1;
          end
        end
        P_NXT: begin
          line_d  = line_q + LINE_W'(1);
`ifdef SEQ_STEP_EN
          phase_d = step_mode ? P_HALT : P_FETCH;
`else
          phase_d = P_FETCH;
`endif
        end
`ifdef SEQ_STEP_EN
        P_HALT: begin
          if (step) phase_d = P_FETCH;
        end
`endif
        P_FINISH: begin
          if (clr) begin
            phase_d  = P_RST;
            sub_clr  = 1'b1;
            calc_clr = 1'b1;
            errq_d   = '0;
          end
        end
        P_ERR: begin
          if (clr) begin
            phase_d  = P_RST;
            sub_clr  = 1'b1;
            calc_clr = 1'b1;
            errq_d   = '0;
            line_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign phase    = phase_q;
  assign line_cnt = line_q;
  assign err_q    = errq_r;
  assign busy     = phase_busy(phase_q);

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl (FETCH=4, WB=1, CALC_TIMEOUT=8, ERR_W=4, LINE_W=2).
// The step-mode scenario is compiled only when SEQ_STEP_EN is defined.
module tb_cpu_seq_ctrl;
  import cpu_seq_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0, clr = 1'b0, stall = 1'b0, nxt_line = 1'b0, finish = 1'b0, err = 1'b0;
  logic [3:0] err_code = '0;
`ifdef SEQ_STEP_EN
  logic       step_mode = 1'b0, step = 1'b0;
`endif
  SeqPhase    phase;
  logic [1:0] sub_idx;
  logic [1:0] line_cnt;
  logic [3:0] err_q;
  logic       busy;

  cpu_seq_ctrl #(
    .FETCH_CYCLES (4),
    .WB_CYCLES    (1),
    .CALC_TIMEOUT (8),
    .ERR_W        (4),
    .LINE_W       (2)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .clr       (clr),
    .stall     (stall),
    .nxt_line  (nxt_line),
    .finish    (finish),
    .err       (err),
    .err_code  (err_code),
`ifdef SEQ_STEP_EN
    .step_mode (step_mode),
    .step      (step),
`endif
    .phase     (phase),
    .sub_idx   (sub_idx),
    .line_cnt  (line_cnt),
    .err_q     (err_q),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    SeqPhase    ph;
    logic [1:0] idx;
    logic [1:0] line;
    logic [3:0] eq;
    logic       busy;
  } obs_t;

  typedef struct {
    int unsigned in;
    logic [3:0]  code;
    obs_t        e;
  } row_t;

  // Input bits: start, nxt_line, finish, err, stall, clr, step_mode, step.
  localparam int unsigned S = 1, N = 2, F = 4, E = 8, T = 16, C = 32, M = 64, P = 128;

  obs_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic row_t mk(int unsigned in, logic [3:0] code, SeqPhase ph,
                              int unsigned idx, int unsigned line, logic [3:0] eq);
    row_t r;
    r.in     = in;
    r.code   = code;
    r.e.ph   = ph;
    r.e.idx  = 2'(idx);
    r.e.line = 2'(line);
    r.e.eq   = eq;
    r.e.busy = !(ph inside {P_RST, P_FINISH, P_ERR});
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{phase, sub_idx, line_cnt, err_q, busy};
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    SeqPhase p;
    p = o.ph;
    return $sformatf("ph=%s idx=%0d line=%0d err_q=%h busy=%b", p.name(), o.idx, o.line, o.eq, o.busy);
  endfunction

  // Applies one cycle of inputs, records the expected post-edge state, advances one clock.
  task automatic drive(input row_t r);
    start    = (r.in & S) != 0;
    nxt_line = (r.in & N) != 0;
    finish   = (r.in & F) != 0;
    err      = (r.in & E) != 0;
    stall    = (r.in & T) != 0;
    clr      = (r.in & C) != 0;
`ifdef SEQ_STEP_EN
    step_mode = (r.in & M) != 0;
    step      = (r.in & P) != 0;
`endif
    err_code = r.code;
    sb.push_back(r.e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    rstn = 1'b0;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp = '{P_RST, 2'd0, 2'd0, 4'h0, 1'b0};
    got = sample();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset: got %s, expected %s", fmt(got), fmt(exp));
    end
    start = 1'b0;
    rstn  = 1'b1;
  endtask

  task automatic test_first_line();
    row_t rows[$];
    obs_t got, exp;
    rows.push_back(mk(S, 0, P_FETCH, 0, 0, 0));
    rows.push_back(mk(C, 0, P_FETCH, 1, 0, 0));
    rows.push_back(mk(0, 0, P_FETCH, 2, 0, 0));
    rows.push_back(mk(0, 0, P_FETCH, 3, 0, 0));
    rows.push_back(mk(0, 0, P_CALC,  0, 0, 0));
    rows.push_back(mk(0, 0, P_CALC,  0, 0, 0));
    rows.push_back(mk(0, 0, P_CALC,  0, 0, 0));
    rows.push_back(mk(N, 0, P_WRITE, 0, 0, 0));
    rows.push_back(mk(0, 0, P_NXT,   0, 0, 0));
    rows.push_back(mk(0, 0, P_FETCH, 0, 1, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp = sb.pop_front();
      got = sample();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL first_line row %0d: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_finish();
    row_t rows[$];
    obs_t got, exp;
    for (int unsigned k = 1; k < 4; k++) rows.push_back(mk(0, 0, P_FETCH, k, 1, 0));
    rows.push_back(mk(0,     0, P_CALC,   0, 1, 0));
    rows.push_back(mk(F | N, 0, P_FINISH, 0, 1, 0));
    rows.push_back(mk(S,     0, P_FINISH, 0, 1, 0));
    rows.push_back(mk(C,     0, P_RST,    0, 1, 0));
    rows.push_back(mk(0,     0, P_RST,    0, 1, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp = sb.pop_front();
      got = sample();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL finish row %0d: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_watchdog();
    row_t rows[$];
    obs_t got, exp;
    rows.push_back(mk(S, 0, P_FETCH, 0, 1, 0));
    for (int unsigned k = 1; k < 4; k++) rows.push_back(mk(0, 0, P_FETCH, k, 1, 0));
    for (int unsigned k = 0; k < 8; k++) rows.push_back(mk(0, 0, P_CALC, 0, 1, 0));
    rows.push_back(mk(0, 0, P_ERR, 0, 1, 4'hF));
    rows.push_back(mk(0, 0, P_ERR, 0, 1, 4'hF));
    rows.push_back(mk(C, 0, P_RST, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp = sb.pop_front();
      got = sample();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL watchdog row %0d: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_err_capture();
    row_t rows[$];
    obs_t got, exp;
    rows.push_back(mk(S, 0,    P_FETCH, 0, 0, 0));
    rows.push_back(mk(0, 0,    P_FETCH, 1, 0, 0));
    rows.push_back(mk(0, 0,    P_FETCH, 2, 0, 0));
    rows.push_back(mk(E, 4'h3, P_ERR,   2, 0, 4'h3));
    rows.push_back(mk(E, 4'h5, P_ERR,   2, 0, 4'h3));
    rows.push_back(mk(0, 0,    P_ERR,   2, 0, 4'h3));
    rows.push_back(mk(C, 0,    P_RST,   0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp = sb.pop_front();
      got = sample();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL err_capture row %0d: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_stall();
    row_t rows[$];
    obs_t got, exp;
    rows.push_back(mk(S | T, 0, P_RST,   0, 0, 0));
    rows.push_back(mk(S,     0, P_FETCH, 0, 0, 0));
    rows.push_back(mk(0,     0, P_FETCH, 1, 0, 0));
    for (int unsigned k = 0; k < 5; k++) rows.push_back(mk(T, 0, P_FETCH, 1, 0, 0));
    rows.push_back(mk(0, 0, P_FETCH, 2, 0, 0));
    rows.push_back(mk(0, 0, P_FETCH, 3, 0, 0));
    for (int unsigned k = 0; k < 4; k++) rows.push_back(mk(0, 0, P_CALC, 0, 0, 0));
    for (int unsigned k = 0; k < 5; k++) rows.push_back(mk(T, 0, P_CALC, 0, 0, 0));
    for (int unsigned k = 0; k < 4; k++) rows.push_back(mk(0, 0, P_CALC, 0, 0, 0));
    rows.push_back(mk(0,     0,    P_ERR,   0, 0, 4'hF));
    rows.push_back(mk(C,     0,    P_RST,   0, 0, 0));
    rows.push_back(mk(S,     0,    P_FETCH, 0, 0, 0));
    rows.push_back(mk(T | E, 4'h2, P_ERR,   0, 0, 4'h2));
    rows.push_back(mk(T | C, 0,    P_ERR,   0, 0, 4'h2));
    rows.push_back(mk(C,     0,    P_RST,   0, 0, 0));
    rows.push_back(mk(E,     4'h6, P_ERR,   0, 0, 4'h6));
    rows.push_back(mk(C,     0,    P_RST,   0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp = sb.pop_front();
      got = sample();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL stall row %0d: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_line_wrap();
    row_t rows[$];
    obs_t got, exp;
    rows.push_back(mk(S, 0, P_FETCH, 0, 0, 0));
    for (int unsigned l = 0; l < 4; l++) begin
      for (int unsigned k = 1; k < 4; k++) rows.push_back(mk(0, 0, P_FETCH, k, l, 0));
      rows.push_back(mk(0, 0, P_CALC,  0, l, 0));
      rows.push_back(mk(N, 0, P_WRITE, 0, l, 0));
      rows.push_back(mk(0, 0, P_NXT,   0, l, 0));
      if (l == 1) rows.push_back(mk(T, 0, P_NXT, 0, l, 0));
      rows.push_back(mk(0, 0, P_FETCH, 0, (l + 1) % 4, 0));
    end
    rows.push_back(mk(E, 4'h1, P_ERR, 0, 0, 4'h1));
    rows.push_back(mk(C, 0,    P_RST, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp = sb.pop_front();
      got = sample();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL line_wrap row %0d: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

`ifdef SEQ_STEP_EN
  task automatic test_step();
    row_t rows[$];
    obs_t got, exp;
    rows.push_back(mk(S | M, 0, P_FETCH, 0, 0, 0));
    for (int unsigned k = 1; k < 4; k++) rows.push_back(mk(M, 0, P_FETCH, k, 0, 0));
    rows.push_back(mk(M,         0,    P_CALC,  0, 0, 0));
    rows.push_back(mk(N | M,     0,    P_WRITE, 0, 0, 0));
    rows.push_back(mk(M,         0,    P_NXT,   0, 0, 0));
    rows.push_back(mk(M,         0,    P_HALT,  0, 1, 0));
    rows.push_back(mk(M,         0,    P_HALT,  0, 1, 0));
    rows.push_back(mk(M | T | P, 0,    P_HALT,  0, 1, 0));
    rows.push_back(mk(M | P,     0,    P_FETCH, 0, 1, 0));
    rows.push_back(mk(E,         4'h7, P_ERR,   0, 1, 4'h7));
    rows.push_back(mk(C,         0,    P_RST,   0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp = sb.pop_front();
      got = sample();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL step row %0d: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask
`endif

  task automatic test_async_reset();
    row_t rows[$];
    obs_t got, exp;
    rows.push_back(mk(S, 0,    P_FETCH, 0, 0, 0));
    rows.push_back(mk(0, 0,    P_FETCH, 1, 0, 0));
    rows.push_back(mk(E, 4'h9, P_ERR,   1, 0, 4'h9));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp = sb.pop_front();
      got = sample();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL async_reset row %0d: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
    // Mid-cycle, no clock edge: reset must act immediately.
    #2 rstn = 1'b0;
    #1;
    exp = '{P_RST, 2'd0, 2'd0, 4'h0, 1'b0};
    got = sample();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL async_reset immediate: got %s, expected %s", fmt(got), fmt(exp));
    end
    err      = 1'b1;
    err_code = 4'hA;
    repeat (2) @(posedge clk);
    #1;
    got = sample();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL async_reset err_held: got %s, expected %s", fmt(got), fmt(exp));
    end
    err  = 1'b0;
    rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_finish();
    test_watchdog();
    test_err_capture();
    test_stall();
    test_line_wrap();
`ifdef SEQ_STEP_EN
    test_step();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
